// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared defaults and FSM state type for adder_arbiter
package adder_arb_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N_REQ = 4;
    typedef enum logic {IDLE, HOLD} state_e;
endpackage

// File: rtl/adder_arbiter_adder.sv
// adder_arbiter_adder: combinational WIDTH-bit adder, s = a + b (mod 2^WIDTH)
//   a, b : operands
//   s    : sum
module adder_arbiter_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s
);
    assign s = a + b;
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one adder among N_REQ requesters
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b        : per-requester operands
//   rsp_valid/rsp_ready : result handshake
//   rsp_sum, rsp_id     : registered sum and owning requester index
//   rsp_carry           : carry-out, present only when ADDER_ARB_CARRY_EN is defined
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_REQ = DEFAULT_N_REQ
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0]    req_a,
    input  logic [N_REQ-1:0][WIDTH-1:0]    req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [WIDTH-1:0]               rsp_sum,
    output logic [$clog2(N_REQ)-1:0]       rsp_id
`ifdef ADDER_ARB_CARRY_EN
    ,
    output logic                           rsp_carry
`endif
);
    localparam int IDW = $clog2(N_REQ);
`ifdef ADDER_ARB_CARRY_EN
    // One extra adder bit yields the carry-out without a second adder.
    localparam int AW = WIDTH + 1;
`else
    localparam int AW = WIDTH;
`endif

    state_e           state, state_next;
    logic [IDW-1:0]   rr_ptr, grant_id, cand;
    logic             grant_any, slot_free, handshake;
    logic [WIDTH-1:0] op_a, op_b;
    logic [AW-1:0]    sum_full;
    int               idx;

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDW'(idx);
            if (req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = handshake ? HOLD : ((state == HOLD && rsp_ready) ? IDLE : state);
    end

    always_comb begin
        rsp_valid = (state == HOLD);
        slot_free = !rsp_valid || rsp_ready;
        handshake = slot_free && grant_any;
        req_ready = handshake ? (N_REQ'(1) << grant_id) : '0;
    end

    // Gate operands so idle or X inputs from non-granted requesters never reach the adder.
    assign op_a = grant_any ? req_a[grant_id] : '0;
    assign op_b = grant_any ? req_b[grant_id] : '0;

    adder_arbiter_adder #(.WIDTH(AW)) u_adder (
        .a (AW'(op_a)),
        .b (AW'(op_b)),
        .s (sum_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sum <= '0;
            rsp_id  <= '0;
            rr_ptr  <= '0;
        end else if (handshake) begin
            rsp_sum <= sum_full[WIDTH-1:0];
            rsp_id  <= grant_id;
            rr_ptr  <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

`ifdef ADDER_ARB_CARRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rsp_carry <= 1'b0;
        else if (handshake) rsp_carry <= sum_full[AW-1];
    end
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and randomized checks of adder_arbiter against a behavioural model
module tb_adder_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0][W-1:0]  req_a = '0;
    logic [N-1:0][W-1:0]  req_b = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [W-1:0]         rsp_sum;
    logic [1:0]           rsp_id;
`ifdef ADDER_ARB_CARRY_EN
    logic                 rsp_carry;
`endif

    int errors = 0;
    int checks = 0;

    logic         m_valid;
    logic [W-1:0] m_sum;
    logic [1:0]   m_id;
    logic         m_carry;
    int           m_ptr;

    adder_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef ADDER_ARB_CARRY_EN
        ,
        .rsp_carry (rsp_carry)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = '0;
        m_id    = '0;
        m_carry = 1'b0;
        m_ptr   = 0;
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_valid && !rsp_ready) return r;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic tick();
        logic [N-1:0] r;
        logic [W:0]   full;
        int           g;
        r = model_ready();
        g = -1;
        full = '0;
        for (int k = 0; k < N; k++) if (r[k]) g = k;
        if (g >= 0) full = {1'b0, req_a[g]} + {1'b0, req_b[g]};
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_sum   = full[W-1:0];
            m_carry = full[W];
            m_id    = 2'(g);
            m_ptr   = (g + 1) % N;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i] = $urandom;
            req_b[i] = $urandom;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rand_ops();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", rsp_valid); end
        checks++; if (rsp_sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0", rsp_sum); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
        req_valid = '0;
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        rand_ops();
        req_valid = 4'b0001; req_a[0] = 32'h0; req_b[0] = 32'h4; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready: got %b want 0001", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", rsp_valid); end
        checks++; if (rsp_sum !== 32'h4) begin errors++; $display("FAIL basic_sum: got %h want 4", rsp_sum); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL basic_id: got %0d want 0", rsp_id); end
    endtask

    task automatic test_req2();
        rand_ops();
        req_valid = 4'b0100; req_a[2] = 32'h4; req_b[2] = 32'hF004;
        #1;
        tick();
        checks++; if (rsp_sum !== 32'hF008) begin errors++; $display("FAIL req2_sum: got %h want f008", rsp_sum); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL req2_id: got %0d want 2", rsp_id); end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL req2_ptr3: got %b want 1000", req_ready); end
        tick();
        checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL req2_next_id: got %0d want 3", rsp_id); end
    endtask

    task automatic test_wrap();
        rand_ops();
        req_valid = 4'b0001; req_a[0] = 32'hFFFF_FFFE; req_b[0] = 32'h2;
        #1;
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %0b want 1", rsp_valid); end
        checks++; if (rsp_sum !== 32'h0) begin errors++; $display("FAIL wrap_sum: got %h want 0", rsp_sum); end
`ifdef ADDER_ARB_CARRY_EN
        checks++; if (rsp_carry !== 1'b1) begin errors++; $display("FAIL wrap_carry: got %0b want 1", rsp_carry); end
`endif
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ids [5];
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req_valid = 4'b1000;
        #1;
        tick();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rand_ops();
            #1;
            checks++; if (req_ready !== (4'b0001 << exp_ids[c])) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, 4'b0001 << exp_ids[c]); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_ids[c]) begin errors++; $display("FAIL rr_id[%0d]: got valid=%0b id=%0d want valid=1 id=%0d", c, rsp_valid, rsp_id, exp_ids[c]); end
            checks++; if (rsp_sum !== m_sum) begin errors++; $display("FAIL rr_sum[%0d]: got %h want %h", c, rsp_sum, m_sum); end
        end
    endtask

    task automatic test_hold();
        rand_ops();
        req_valid = 4'b0010; req_a[1] = 32'h3; req_b[1] = 32'h5; rsp_ready = 1'b1;
        #1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0000", c, req_ready); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h8 || rsp_id !== 2'd1) begin errors++; $display("FAIL hold_stable[%0d]: got valid=%0b sum=%h id=%0d want valid=1 sum=8 id=1", c, rsp_valid, rsp_sum, rsp_id); end
        end
        rsp_ready = 1'b1;
        req_a[2] = 32'd10; req_b[2] = 32'd20;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL drain_ready: got %b want 0100", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd30 || rsp_id !== 2'd2) begin errors++; $display("FAIL drain_load: got valid=%0b sum=%h id=%0d want valid=1 sum=1e id=2", rsp_valid, rsp_sum, rsp_id); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 4'b0000;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %0b want 1", rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_sum !== '0) begin errors++; $display("FAIL midrst_async: got valid=%0b sum=%h want valid=0 sum=0", rsp_valid, rsp_sum); end
        model_reset();
        rand_ops();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_noload: got %0b want 0", rsp_valid); end
        #1 rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ready: got %b want 0001", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== m_sum) begin errors++; $display("FAIL midrst_first: got valid=%0b id=%0d sum=%h want valid=1 id=0 sum=%h", rsp_valid, rsp_id, rsp_sum, m_sum); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (req_ready !== model_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, model_ready()); end
            tick();
            checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %0b want %0b", c, rsp_valid, m_valid); end
            if (m_valid) begin
                checks++; if (rsp_sum !== m_sum || rsp_id !== m_id) begin errors++; $display("FAIL rand_result[%0d]: got sum=%h id=%0d want sum=%h id=%0d", c, rsp_sum, rsp_id, m_sum, m_id); end
`ifdef ADDER_ARB_CARRY_EN
                checks++; if (rsp_carry !== m_carry) begin errors++; $display("FAIL rand_carry[%0d]: got %0b want %0b", c, rsp_carry, m_carry); end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req2();
        test_wrap();
        test_round_robin();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero.
REQ-007 SHALL have port req_a  input  N_REQ x WIDTH  operand A per requester.
REQ-008 SHALL have port req_b  input  N_REQ x WIDTH  operand B per requester.
REQ-009 SHALL have port rsp_valid  output  1  result register holds a valid sum.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_sum  output  WIDTH  registered sum.
REQ-012 SHALL have port rsp_id  output  clog2(N_REQ)  index of requester owning rsp_sum.

Function
REQ-013 SHALL share one adder instance among all requesters; one operation accepted per cycle max.
REQ-014 SHALL have states IDLE (rsp_valid=0) and HOLD (rsp_valid=1).
REQ-015 SHALL define slot_free = !rsp_valid || rsp_ready.
REQ-016 SHALL, when slot_free, grant the first valid requester at or after rr_ptr in round-robin order; req_ready combinational from req_valid, rr_ptr, rsp_valid, rsp_ready.
REQ-017 SHALL assert req_ready[i] only when req_valid[i]=1 and i is granted; a handshake is req_valid[i]&&req_ready[i].
REQ-018 SHALL, on a handshake at edge N, present rsp_sum=(req_a[i]+req_b[i]) mod 2^WIDTH and rsp_id=i with rsp_valid=1 after edge N (latency 1 cycle).
REQ-019 SHALL, on a handshake, set rr_ptr to (i+1) mod N_REQ; rr_ptr unchanged otherwise.
REQ-020 SHALL in HOLD keep rsp_sum/rsp_id/rsp_valid stable while rsp_ready=0, and drive req_ready all zero.
REQ-021 SHALL, on simultaneous drain (rsp_ready=1 in HOLD) and new grant, load the new result in the same edge (HOLD->HOLD, full throughput).
REQ-022 SHALL go HOLD->IDLE on drain with no grant, IDLE->HOLD on grant, else hold state.
REQ-023 SHALL ignore operand values of non-granted requesters; no X propagation from them.

Reset
REQ-024 SHALL, while rst_n=0, force rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0, state IDLE, independent of clk.
REQ-025 SHALL drop an in-flight result on reset mid-HOLD; no handshake completes in the reset cycle.

Configuration
REQ-026 SHALL, with macro ADDER_ARB_CARRY_EN defined, add port rsp_carry  output  1  carry-out of the WIDTH-bit add, registered alongside rsp_sum, reset 0.
REQ-027 SHALL, without ADDER_ARB_CARRY_EN, omit rsp_carry and all carry logic; other behaviour identical.

Structure
REQ-028 SHALL place default WIDTH, default N_REQ, and typedef state_e {IDLE, HOLD} in package adder_arb_pkg.
REQ-029 SHALL instantiate the existing parameterized adder (ports a, b, s) as the sole sub-module; arbitration and result register in adder_arbiter.

Verification
REQ-030 SHALL cover: req_valid=0001, a=0x0, b=0x4, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=0x4, rsp_id=0.
REQ-031 SHALL cover: req2 a=0x4, b=0xF004 -> rsp_sum=0xF008, rsp_id=2, rr_ptr=3.
REQ-032 SHALL cover: a=0xFFFFFFFE, b=0x2 -> rsp_sum=0x0; with ADDER_ARB_CARRY_EN rsp_carry=1.
REQ-033 SHALL cover: req_valid=1111 held, rsp_ready=1 -> rsp_id 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-034 SHALL cover: result 0x8 in HOLD, rsp_ready=0 for 3 cycles -> rsp_sum stable 0x8, req_ready=0000; rsp_ready=1 -> drain and next grant same edge.
REQ-035 SHALL cover: rst_n=0 mid-HOLD -> rsp_valid=0 without clk edge; after release req_valid=1111 -> first rsp_id=0.
